// File: rtl/sd_arb_pkg.sv
// rtl/sd_arb_pkg.sv - shared state type, data-width helper and limits for the SD block-I/O arbiter
package sd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_BUSY    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam int SD_ARB_MAX_DRV = 8;

    // Top bit index of the sector-buffer data bus: 8-bit or 16-bit.
    function automatic int sd_dw(input int wide);
        return (wide != 0) ? 15 : 7;
    endfunction

endpackage

// File: rtl/sd_rr_pick.sv
// rtl/sd_rr_pick.sv - combinational round-robin picker: first set req at or after ptr, wrapping
module sd_rr_pick
    import sd_arb_pkg::*;
#(
    parameter  int NUM_DRV = 4,
    localparam int IW      = $clog2(NUM_DRV)
) (
    input  logic [NUM_DRV-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               valid,
    output logic [IW-1:0]      idx
);

    // Walk offsets from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        logic [IW-1:0] cand;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = SD_ARB_MAX_DRV - 1; k >= 0; k--) begin
            if (k < NUM_DRV) begin
                cand = IW'((int'(ptr) + k) % NUM_DRV);
                if (req[cand]) begin
                    valid = 1'b1;
                    idx   = cand;
                end
            end
        end
    end

endmodule

// File: rtl/sd_io_arbiter.sv
// rtl/sd_io_arbiter.sv - round-robin sharing of the host block-I/O channel between drive emulators
// Optional transfer timeout enabled by defining SD_ARB_TIMEOUT_EN.
module sd_io_arbiter
    import sd_arb_pkg::*;
#(
    parameter  int NUM_DRV = 4,
    parameter  int WIDE    = 0,
    parameter  int TO_W    = 24,
    localparam int DW      = sd_dw(WIDE),
    localparam int IW      = $clog2(NUM_DRV)
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic [NUM_DRV*32-1:0]     drv_lba,
    input  logic [NUM_DRV-1:0]        drv_rd,
    input  logic [NUM_DRV-1:0]        drv_wr,
    output logic [NUM_DRV-1:0]        drv_ack,
    output logic [NUM_DRV-1:0]        drv_buff_wr,
    input  logic [NUM_DRV*(DW+1)-1:0] drv_buff_din,
    output logic [31:0]               sd_lba,
    output logic                      sd_rd,
    output logic                      sd_wr,
    output logic [IW-1:0]             sd_drv,
    input  logic                      sd_ack,
    input  logic                      sd_buff_wr,
    output logic [DW:0]               sd_buff_din,
    output logic                      sd_timeout
);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      g_q, g_d;
    logic [31:0]        lba_q, lba_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [NUM_DRV-1:0] req;
    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               in_xfer;

`ifdef SD_ARB_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               to_pulse_q, to_pulse_d;
`endif

    assign req = drv_rd | drv_wr;

    sd_rr_pick #(.NUM_DRV(NUM_DRV)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        lba_d   = lba_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef SD_ARB_TIMEOUT_EN
        to_cnt_d   = to_cnt_q + 1'b1;
        to_pulse_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    g_d     = pick_idx;
                    lba_d   = drv_lba[32*int'(pick_idx) +: 32];
                    rd_d    = drv_rd[pick_idx];
                    wr_d    = ~drv_rd[pick_idx];
                    state_d = ST_ISSUE;
`ifdef SD_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            ST_ISSUE: begin
                if (sd_ack) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_BUSY;
`ifdef SD_ARB_TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end else if (!req[g_q]) begin
                    // Withdrawn before the host took it: no transfer happened, so ptr stays.
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    state_d = ST_IDLE;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (&to_cnt_q) begin
                    rd_d       = 1'b0;
                    wr_d       = 1'b0;
                    to_pulse_d = 1'b1;
                    state_d    = ST_RELEASE;
                end
`endif
            end
            ST_BUSY: begin
                if (!sd_ack) begin
                    state_d = ST_RELEASE;
                end
`ifdef SD_ARB_TIMEOUT_EN
                else if (&to_cnt_q) begin
                    to_pulse_d = 1'b1;
                    state_d    = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                ptr_d   = IW'((int'(g_q) + 1) % NUM_DRV);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            lba_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef SD_ARB_TIMEOUT_EN
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            lba_q   <= lba_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef SD_ARB_TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_pulse_q <= to_pulse_d;
`endif
        end
    end

    // Host acks outside ISSUE/BUSY belong to nobody and are dropped.
    assign in_xfer     = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
    assign drv_ack     = (sd_ack && in_xfer) ? (NUM_DRV'(1) << g_q) : '0;
    assign drv_buff_wr = drv_ack & {NUM_DRV{sd_buff_wr}};
    assign sd_buff_din = drv_buff_din[(DW+1)*int'(g_q) +: (DW+1)];
    assign sd_lba      = lba_q;
    assign sd_rd       = rd_q;
    assign sd_wr       = wr_q;
    assign sd_drv      = g_q;

`ifdef SD_ARB_TIMEOUT_EN
    assign sd_timeout = to_pulse_q;
`else
    assign sd_timeout = (TO_W < 1);
`endif

endmodule

// File: tb/tb_sd_io_arbiter.sv
// tb/tb_sd_io_arbiter.sv - scoreboard bench for sd_io_arbiter with randomized request rounds
module tb_sd_io_arbiter;

    localparam int N = 4;

    logic            clk_sys      = 1'b0;
    logic            reset        = 1'b1;
    logic [N*32-1:0] drv_lba      = '0;
    logic [N-1:0]    drv_rd       = '0;
    logic [N-1:0]    drv_wr       = '0;
    logic [N-1:0]    drv_ack;
    logic [N-1:0]    drv_buff_wr;
    logic [N*8-1:0]  drv_buff_din = '0;
    logic [31:0]     sd_lba;
    logic            sd_rd;
    logic            sd_wr;
    logic [1:0]      sd_drv;
    logic            sd_ack       = 1'b0;
    logic            sd_buff_wr   = 1'b0;
    logic [7:0]      sd_buff_din;
    logic            sd_timeout;

    sd_io_arbiter #(.NUM_DRV(N), .WIDE(0), .TO_W(24)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .drv_lba      (drv_lba),
        .drv_rd       (drv_rd),
        .drv_wr       (drv_wr),
        .drv_ack      (drv_ack),
        .drv_buff_wr  (drv_buff_wr),
        .drv_buff_din (drv_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_drv       (sd_drv),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .sd_timeout   (sd_timeout)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int          drv;
        logic [31:0] lba;
        logic        rd;
        logic [7:0]  data;
    } xfer_t;

    xfer_t       exp_q[$];
    int          checks    = 0;
    int          errors    = 0;
    int          cyc       = 0;
    int          round_id  = 0;
    int          req_cyc   = 0;
    int          m_ptr     = 0;
    int          hlen      = 0;
    bit          mon_en    = 1'b0;
    bit          host_auto = 1'b0;
    logic [31:0] lba_tab [N];
    logic [7:0]  dat_tab [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // One negedge: drives drop requests they see acked, host model answers strobes.
    task automatic tick();
        @(negedge clk_sys);
        for (int i = 0; i < N; i++) begin
            if (drv_ack[i]) begin
                drv_rd[i] = 1'b0;
                drv_wr[i] = 1'b0;
            end
        end
        if (host_auto) begin
            if (sd_ack) begin
                if (hlen == 0) begin
                    sd_ack     = 1'b0;
                    sd_buff_wr = 1'b0;
                end else begin
                    hlen--;
                    sd_buff_wr = 1'($urandom);
                end
            end else if ((sd_rd || sd_wr) && $urandom_range(0, 2) == 0) begin
                sd_ack     = 1'b1;
                hlen       = $urandom_range(1, 4);
                sd_buff_wr = 1'($urandom);
            end
        end
    endtask

    task automatic rand_tables();
        for (int i = 0; i < N; i++) begin
            lba_tab[i] = $urandom;
            dat_tab[i] = 8'($urandom);
        end
    endtask

    // Each requester is served once; order is requesters sorted by distance from ptr.
    task automatic start_round(input logic [N-1:0] rd, input logic [N-1:0] wr);
        int    last;
        xfer_t x;
        last = -1;
        for (int k = 0; k < N; k++) begin
            int d;
            d = (m_ptr + k) % N;
            if (rd[d] || wr[d]) begin
                x.drv  = d;
                x.lba  = lba_tab[d];
                x.rd   = rd[d];
                x.data = dat_tab[d];
                exp_q.push_back(x);
                last = d;
            end
        end
        if (last >= 0) m_ptr = (last + 1) % N;
        for (int i = 0; i < N; i++) begin
            drv_lba[32*i +: 32]     = lba_tab[i];
            drv_buff_din[8*i +: 8]  = dat_tab[i];
        end
        round_id++;
        req_cyc = cyc;
        drv_rd  = rd;
        drv_wr  = wr;
    endtask

    task automatic wait_round();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || sd_ack || (drv_rd | drv_wr) != '0) && t < 400) begin
            tick();
            t++;
        end
        chk("round_done", 64'(t < 400), 64'd1);
        repeat (3) tick();
    endtask

    task automatic do_reset();
        mon_en     = 1'b0;
        host_auto  = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        drv_rd     = '0;
        drv_wr     = '0;
        reset      = 1'b1;
        repeat (2) tick();
        reset      = 1'b0;
        m_ptr      = 0;
        exp_q.delete();
        tick();
    endtask

    // Monitor: pops an expected transfer on every strobe rise and checks routing during ack.
    xfer_t cur;
    bit    cur_valid   = 1'b0;
    bit    gap_armed   = 1'b0;
    bit    prev_strobe = 1'b0;
    bit    prev_ack    = 1'b0;
    int    fall_cyc    = 0;
    int    mon_round   = 0;

    always begin
        logic strobe;
        @(posedge clk_sys);
        #1;
        cyc++;
        strobe = sd_rd | sd_wr;
        if (mon_en) begin
            if (strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(sd_drv), 64'hFFFF);
                end else begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    chk("grant_drv", 64'(sd_drv), 64'(cur.drv));
                    chk("grant_lba", 64'(sd_lba), 64'(cur.lba));
                    chk("strobe_kind", 64'({sd_rd, sd_wr}), cur.rd ? 64'd2 : 64'd1);
                    if (mon_round != round_id) begin
                        mon_round = round_id;
                        chk("req_latency", 64'(cyc - req_cyc), 64'd1);
                    end else if (gap_armed) begin
                        chk("ack_fall_gap", 64'(cyc - fall_cyc), 64'd2);
                    end
                    gap_armed = 1'b0;
                end
            end
            if (sd_ack && cur_valid) begin
                chk("ack_route", 64'(drv_ack), 64'd1 << cur.drv);
                chk("buff_din", 64'(sd_buff_din), 64'(cur.data));
                chk("buff_wr_route", 64'(drv_buff_wr), sd_buff_wr ? (64'd1 << cur.drv) : 64'd0);
                chk("strobe_clr", 64'(strobe), 64'd0);
            end
            if (!sd_ack && prev_ack && cur_valid) begin
                cur_valid = 1'b0;
                fall_cyc  = cyc;
                gap_armed = (exp_q.size() != 0);
            end
        end else begin
            cur_valid = 1'b0;
            gap_armed = 1'b0;
        end
        prev_strobe = strobe;
        prev_ack    = sd_ack;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Reset state, with a stray host ack present.
        repeat (2) tick();
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        tick();
        chk("rst_sd_rd", 64'(sd_rd), 64'd0);
        chk("rst_sd_wr", 64'(sd_wr), 64'd0);
        chk("rst_sd_lba", 64'(sd_lba), 64'd0);
        chk("rst_sd_drv", 64'(sd_drv), 64'd0);
        chk("rst_drv_ack", 64'(drv_ack), 64'd0);
        chk("rst_buff_wr", 64'(drv_buff_wr), 64'd0);
        chk("rst_timeout", 64'(sd_timeout), 64'd0);
        do_reset();

        // Single read on drive 2.
        mon_en = 1'b1; host_auto = 1'b1;
        rand_tables();
        lba_tab[2] = 32'h1234;
        start_round(4'b0100, 4'b0000);
        wait_round();

        // Fairness from reset: two full rounds give 0,1,2,3,0,1,2,3.
        do_reset();
        mon_en = 1'b1; host_auto = 1'b1;
        for (int r = 0; r < 2; r++) begin
            rand_tables();
            start_round(4'b1111, 4'b0000);
            wait_round();
        end

        // Read and write both set on the same drive: read wins.
        rand_tables();
        start_round(4'b0001, 4'b0001);
        wait_round();

        // Write routing with distinct data on drive 1 only.
        rand_tables();
        for (int i = 0; i < N; i++) dat_tab[i] = 8'h00;
        dat_tab[1] = 8'hA5;
        start_round(4'b0000, 4'b0010);
        wait_round();

        // Random mixes.
        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] rd, wr;
            rd = N'($urandom);
            wr = N'($urandom);
            rand_tables();
            if ((rd | wr) != '0) begin
                start_round(rd, wr);
                wait_round();
            end
        end

        // Withdrawal in ISSUE keeps the pointer where it was (3 after serving drive 2).
        do_reset();
        mon_en = 1'b1; host_auto = 1'b1;
        rand_tables();
        start_round(4'b0100, 4'b0000);
        wait_round();
        mon_en = 1'b0; host_auto = 1'b0;
        drv_rd[3] = 1'b1;
        repeat (2) tick();
        chk("wd_strobe", 64'(sd_rd), 64'd1);
        chk("wd_drv", 64'(sd_drv), 64'd3);
        drv_rd[3] = 1'b0;
        tick();
        chk("wd_strobe_clr", 64'(sd_rd | sd_wr), 64'd0);
        chk("wd_no_ack", 64'(drv_ack), 64'd0);
        repeat (3) tick();
        mon_en = 1'b1; host_auto = 1'b1;
        rand_tables();
        start_round(4'b1001, 4'b0000);
        wait_round();

        // Reset while BUSY with the host ack still high.
        mon_en = 1'b0; host_auto = 1'b0;
        drv_rd[1] = 1'b1;
        repeat (2) tick();
        chk("rb_strobe", 64'(sd_rd), 64'd1);
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        tick();
        chk("rb_busy_ack", 64'(drv_ack), 64'b0010);
        chk("rb_busy_bwr", 64'(drv_buff_wr), 64'b0010);
        reset = 1'b1;
        tick();
        chk("rb_drv_ack", 64'(drv_ack), 64'd0);
        chk("rb_buff_wr", 64'(drv_buff_wr), 64'd0);
        chk("rb_strobes", 64'({sd_rd, sd_wr}), 64'd0);
        chk("rb_lba", 64'(sd_lba), 64'd0);
        chk("rb_drv", 64'(sd_drv), 64'd0);
        reset      = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
